// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite request/response bundle between an interconnect slave port and the SRAM slave.
// The master modport drives the request side and HREADY; the slave modport drives HRDATA/HREADYOUT/HRESP.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite word SRAM slave: OKAY data phase 1+WAIT_STATES cycles, ERROR 2 cycles, stalls via HREADYOUT low.
// Define AHB3LITE_SRAM_PRIV_EN to answer user-mode (HPROT[1]=0) writes with ERROR.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb3lite_sram_slave_if.slave bus
);
  localparam int BYTES = HDATA_SIZE / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             write_q, write_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [BYTES-1:0] be_q, be_d;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic                  ready, take, err, priv_err, we;
  logic [BYTES-1:0]      be_new;
  logic [HADDR_SIZE-1:0] word_idx;
  int                    nbytes, offs;
  logic                  unused_ok;

`ifdef AHB3LITE_SRAM_PRIV_EN
  assign priv_err  = bus.HWRITE & ~bus.HPROT[1];
  assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2], bus.HPROT[0], bus.HTRANS[0]};
`else
  assign priv_err  = 1'b0;
  assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.HTRANS[0]};
`endif

  // Address-phase decode: range, size and alignment checks plus the byte-lane mask.
  always_comb begin
    nbytes   = 1 << bus.HSIZE;
    offs     = 32'(bus.HADDR) & (BYTES - 1);
    word_idx = bus.HADDR >> LOG2B;
    err      = (word_idx >= HADDR_SIZE'(MEM_DEPTH)) ||
               (bus.HSIZE > 3'(LOG2B)) ||
               ((offs & (nbytes - 1)) != 0) ||
               priv_err;
    for (int i = 0; i < BYTES; i++) begin
      be_new[i] = (i >= offs) && (i < offs + nbytes);
    end
  end

  always_comb begin
    ready = 1'b1;
    case (state_q)
      S_DATA:  ready = (cnt_q == 4'd0);
      S_ERR1:  ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  assign take = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    write_d = write_q;
    idx_d   = idx_q;
    be_d    = be_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (!ready) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      // Last cycle of the current data phase (or idle): the next address phase is decided here.
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      pend_d  = take & ~err;
      if (take) begin
        write_d = bus.HWRITE;
        idx_d   = IDXW'(word_idx);
        be_d    = be_new;
        if (err) begin
          state_d = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = S_DATA;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
    end
  end

  assign we = pend_q & write_q & ready;

  // Storage is deliberately unreset; pend_q clearing under reset is what drops a half-done write.
  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.HRDATA    = (pend_q & ~write_q & ready) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: two instances (0 and 3 wait states) on a shared stimulus bus,
// expected responses from a reference memory model queued at address phase and popped at data-phase end.
module tb_ahb3lite_sram_slave;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b0 ();
  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b1 ();

  logic        sel;
  logic        hsel;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  assign b0.HSEL = hsel & ~sel;      assign b1.HSEL = hsel & sel;
  assign b0.HADDR = haddr;           assign b1.HADDR = haddr;
  assign b0.HWDATA = hwdata;         assign b1.HWDATA = hwdata;
  assign b0.HWRITE = hwrite;         assign b1.HWRITE = hwrite;
  assign b0.HSIZE = hsize;           assign b1.HSIZE = hsize;
  assign b0.HBURST = 3'b000;         assign b1.HBURST = 3'b000;
  assign b0.HPROT = hprot;           assign b1.HPROT = hprot;
  assign b0.HTRANS = htrans;         assign b1.HTRANS = htrans;
  assign b0.HMASTLOCK = 1'b0;        assign b1.HMASTLOCK = 1'b0;
  assign b0.HREADY = b0.HREADYOUT;   assign b1.HREADY = b1.HREADYOUT;

  wire        rdy   = sel ? b1.HREADYOUT : b0.HREADYOUT;
  wire        resp  = sel ? b1.HRESP     : b0.HRESP;
  wire [31:0] rdata = sel ? b1.HRDATA    : b0.HRDATA;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) u0 (.HCLK(clk), .HRESETn(rst_n), .bus(b0));
  ahb3lite_sram_slave #(.WAIT_STATES(3)) u1 (.HCLK(clk), .HRESETn(rst_n), .bus(b1));

  typedef struct {logic [31:0] a; logic w; logic [2:0] sz; logic [31:0] wd; logic [3:0] pr;} op_t;
  typedef struct {logic [31:0] rdata; logic resp; int waits;} exp_t;
  typedef struct {logic [31:0] rd; logic rf; logic rl; int waits; logic [31:0] ror; logic tmo;} res_t;

  op_t         ops_q[$];
  exp_t        sb[$];
  res_t        res_q[$];
  logic [31:0] mdl [2][256];
  int          total = 0;
  int          bad = 0;

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [3:0] pr);
    op_t o;
    o.a = a; o.w = w; o.sz = sz; o.wd = wd; o.pr = pr;
    ops_q.push_back(o);
  endtask

  // Reference model: decides OKAY/ERROR and latency, applies writes lane by lane.
  task automatic push_exp(input op_t o);
    exp_t e;
    int   nb, off, idx;
    logic is_err;
    nb     = 1 << o.sz;
    off    = int'(o.a % 4);
    is_err = (o.a >= 32'h400) || (o.sz > 3'd2) || ((o.a % nb) != 0);
`ifdef AHB3LITE_SRAM_PRIV_EN
    if (o.w && !o.pr[1]) is_err = 1'b1;
`endif
    e.rdata = 32'h0;
    e.resp  = is_err;
    e.waits = is_err ? 1 : (sel ? 3 : 0);
    if (!is_err) begin
      idx = int'(o.a >> 2);
      if (o.w) begin
        for (int b = 0; b < 4; b++)
          if (b >= off && b < off + nb) mdl[sel][idx][8*b +: 8] = o.wd[8*b +: 8];
      end else begin
        e.rdata = mdl[sel][idx];
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive_addr(input op_t o);
    hsel = 1'b1; htrans = 2'b10; haddr = o.a; hwrite = o.w; hsize = o.sz; hprot = o.pr;
    push_exp(o);
  endtask

  // Pipelined driver: each next address phase overlaps the current data phase. Starts/ends at posedge+1.
  task automatic run_seq(input logic s);
    op_t  cur, nxt;
    res_t r;
    int   n;
    logic atmo, first;
    sel = s;
    cur = ops_q.pop_front();
    drive_addr(cur);
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy && n < 40);
    atmo = !rdy;
    @(posedge clk); #1;
    forever begin
      hwdata = cur.wd;
      if (ops_q.size() > 0) begin
        nxt = ops_q.pop_front();
        drive_addr(nxt);
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      r.rd = '0; r.rf = 1'b0; r.rl = 1'b0; r.waits = 0; r.ror = '0; r.tmo = 1'b1;
      first = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        r.ror = r.ror | rdata;
        if (first) begin r.rf = resp; first = 1'b0; end
        if (rdy) begin r.rd = rdata; r.rl = resp; r.tmo = 1'b0; break; end
        r.waits++;
      end
      r.tmo = r.tmo | atmo;
      atmo = 1'b0;
      res_q.push_back(r);
      @(posedge clk); #1;
      if (hsel == 1'b0) break;
      cur = nxt;
    end
  endtask

  task automatic test_reset();
    if (b0.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout0 got %b want 1", b0.HREADYOUT); end
    total++;
    if (b0.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp0 got %b want 0", b0.HRESP); end
    total++;
    if (b0.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata0 got %h want 0", b0.HRDATA); end
    total++;
    if (b1.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout1 got %b want 1", b1.HREADYOUT); end
    total++;
    if (b1.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp1 got %b want 0", b1.HRESP); end
    total++;
    if (b1.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata1 got %h want 0", b1.HRDATA); end
    total++;
  endtask

  // Pops one result per completed data phase and checks it against the model.
  `define CHECK_RESULTS(TAG) \
    while (res_q.size() > 0) begin \
      r = res_q.pop_front(); e = sb.pop_front(); i++; \
      total++; if (r.tmo !== 1'b0) begin bad++; $display("FAIL %s_timeout op%0d got no completion want completion", TAG, i); end \
      total++; if (r.rf !== e.resp || r.rl !== e.resp) begin bad++; $display("FAIL %s_hresp op%0d got first=%b last=%b want %b", TAG, i, r.rf, r.rl, e.resp); end \
      total++; if (r.waits !== e.waits) begin bad++; $display("FAIL %s_waits op%0d got %0d want %0d", TAG, i, r.waits, e.waits); end \
      total++; if (r.rd !== e.rdata) begin bad++; $display("FAIL %s_hrdata op%0d got %h want %h", TAG, i, r.rd, e.rdata); end \
      if (e.resp) begin total++; if (r.ror !== 32'h0) begin bad++; $display("FAIL %s_err_hrdata op%0d got %h want 0", TAG, i, r.ror); end end \
    end

  task automatic test_zero_wait();
    res_t r; exp_t e; int i = 0;
    add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'h3); run_seq(1'b0);
    add(32'h10, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b0);
    add(32'h3FC, 1'b1, 3'd2, 32'h600DF00D, 4'h3); run_seq(1'b0);
    add(32'h3FC, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b0);
    `CHECK_RESULTS("zero_wait")
  endtask

  task automatic test_wait_states();
    res_t r; exp_t e; int i = 0;
    add(32'h0, 1'b1, 3'd2, 32'h5A5AC3C3, 4'h3); run_seq(1'b1);
    add(32'h0, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b1);
    add(32'h404, 1'b0, 3'd2, 32'h0, 4'h3);      run_seq(1'b1);
    `CHECK_RESULTS("wait_states")
  endtask

  task automatic test_byte_lanes();
    res_t r; exp_t e; int i = 0;
    add(32'h10, 1'b1, 3'd2, 32'h11223344, 4'h3); run_seq(1'b0);
    add(32'h11, 1'b1, 3'd0, 32'h0000AA00, 4'h3); run_seq(1'b0);
    add(32'h10, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b0);
    add(32'h12, 1'b1, 3'd1, 32'h99880000, 4'h3); run_seq(1'b0);
    add(32'h10, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b0);
    `CHECK_RESULTS("byte_lanes")
  endtask

  task automatic test_errors();
    res_t r; exp_t e; int i = 0;
    add(32'h0, 1'b1, 3'd2, 32'hA5A5A5A5, 4'h3); run_seq(1'b0);
    add(32'h400, 1'b0, 3'd2, 32'h0, 4'h3);      run_seq(1'b0);
    add(32'h3, 1'b1, 3'd1, 32'hFFFFFFFF, 4'h3); run_seq(1'b0);
    add(32'h0, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b0);
    add(32'h8, 1'b0, 3'd3, 32'h0, 4'h3);        run_seq(1'b0);
    add(32'h2, 1'b1, 3'd2, 32'h12121212, 4'h3); run_seq(1'b0);
    add(32'h0, 1'b0, 3'd2, 32'h0, 4'h3);        run_seq(1'b0);
    `CHECK_RESULTS("errors")
  endtask

  task automatic test_priv();
    res_t r; exp_t e; int i = 0;
    add(32'h20, 1'b1, 3'd2, 32'h12345678, 4'b0011); run_seq(1'b0);
    add(32'h20, 1'b1, 3'd2, 32'hCAFEF00D, 4'b0001); run_seq(1'b0);
    add(32'h20, 1'b0, 3'd2, 32'h0, 4'b0001);        run_seq(1'b0);
    add(32'h20, 1'b1, 3'd2, 32'h0BB0CAFE, 4'b0011); run_seq(1'b0);
    add(32'h20, 1'b0, 3'd2, 32'h0, 4'b0000);        run_seq(1'b0);
    `CHECK_RESULTS("priv")
  endtask

  task automatic test_back_to_back();
    res_t r; exp_t e; int i = 0;
    add(32'h30, 1'b1, 3'd2, 32'h0BADF00D, 4'h3);
    add(32'h30, 1'b0, 3'd2, 32'h0, 4'h3);
    add(32'h32, 1'b1, 3'd1, 32'hBEEF0000, 4'h3);
    add(32'h30, 1'b0, 3'd2, 32'h0, 4'h3);
    add(32'h800, 1'b0, 3'd2, 32'h0, 4'h3);
    add(32'h30, 1'b0, 3'd2, 32'h0, 4'h3);
    run_seq(1'b0);
    add(32'h34, 1'b1, 3'd2, 32'h01020304, 4'h3);
    add(32'h34, 1'b0, 3'd2, 32'h0, 4'h3);
    add(32'h37, 1'b1, 3'd0, 32'h7F000000, 4'h3);
    add(32'h34, 1'b0, 3'd2, 32'h0, 4'h3);
    add(32'h1000, 1'b0, 3'd2, 32'h0, 4'h3);
    add(32'h34, 1'b0, 3'd2, 32'h0, 4'h3);
    run_seq(1'b1);
    `CHECK_RESULTS("back_to_back")
  endtask

  task automatic test_reset_mid();
    res_t r; exp_t e; int i = 0;
    add(32'h40, 1'b1, 3'd2, 32'h00000055, 4'h3); run_seq(1'b1);
    // Write left in its wait states and then killed by reset; not entered in the model.
    sel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; hprot = 4'h3;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    if (rdy !== 1'b0) begin bad++; $display("FAIL reset_mid_stall got hreadyout=%b want 0", rdy); end
    total++;
    #1 rst_n = 1'b0;
    #1;
    if (rdy !== 1'b1) begin bad++; $display("FAIL reset_mid_hreadyout got %b want 1", rdy); end
    total++;
    if (resp !== 1'b0) begin bad++; $display("FAIL reset_mid_hresp got %b want 0", resp); end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_mid_hrdata got %h want 0", rdata); end
    total++;
    @(posedge clk); @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    add(32'h40, 1'b0, 3'd2, 32'h0, 4'h3); run_seq(1'b1);
    add(32'h10, 1'b0, 3'd2, 32'h0, 4'h3); run_seq(1'b0);
    `CHECK_RESULTS("reset_mid")
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got hang want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwdata = '0;
    hwrite = 1'b0; hsize = 3'd2; hprot = 4'h3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_zero_wait();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_priv();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
